param_cache_ctrl: RTL and testbench
===================================

Name: param_cache_ctrl

Overview:
- Parametrised, read-only, blocking cache controller; next generation of the existing direct-mapped 4-word-block cache.
- Sits between a word-addressed requester and main memory.
- Adds: configurable geometry, 1- or 2-way set associativity with LRU replacement, a req/ready miss handshake to memory (the current cache assumes a combinational memory), and hit/access statistics counters.

Parameters:
- ADDR_W, 15, word-address width.
- DATA_W, 32, word width.
- WORDS_PER_BLOCK, 4, words per line; power of 2, ≥2.
- NUM_SETS, 1024, sets; power of 2.
- WAYS, 1, associativity; 1 or 2 only.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cpu_req  in  1  request strobe; accepted only when cpu_ready=1.
- cpu_addr  in  ADDR_W  word address, sampled on acceptance.
- cpu_ready  out  1  controller idle and able to accept a request.
- cpu_valid  out  1  one-cycle pulse; cpu_rdata and cpu_hit are valid.
- cpu_rdata  out  DATA_W  read word.
- cpu_hit  out  1  response was a hit (qualified by cpu_valid).
- mem_req  out  1  line-fill request; held until the handshake completes.
- mem_addr  out  ADDR_W  block-aligned address (offset bits 0).
- mem_ready  in  1  memory has the line on mem_data this cycle.
- mem_data  in  WORDS_PER_BLOCK*DATA_W  line; word i on bits [i*DATA_W +: DATA_W].
- hit_cnt  out  CNT_W  number of hit responses.
- access_cnt  out  CNT_W  number of accepted requests.

Behaviour:
- Address split:
  - OFF_W = log2(WORDS_PER_BLOCK); IDX_W = log2(NUM_SETS); TAG_W = ADDR_W-IDX_W-OFF_W.
  - TAG_W ≥ 1 is required; defaults give 3/10/2.
- Reset (rst=0, async):
  - state IDLE; all valid bits and LRU bits cleared; counters 0.
  - cpu_valid=0, cpu_hit=0, cpu_rdata=0, mem_req=0, mem_addr=0, cpu_ready=1.
  - Data/tag arrays are not cleared.
- FSM IDLE:
  - cpu_ready=1.
  - cpu_req=1 → latch address, access_cnt++ (saturating), → LOOKUP.
- FSM LOOKUP:
  - Compare the tag in every way of the indexed set (valid & tag match).
  - Hit → register the word, cpu_valid=1, cpu_hit=1, hit_cnt++ (saturating), update LRU, → IDLE.
  - Miss → mem_req=1, mem_addr={tag,idx,0}, → FILL.
- FSM FILL:
  - mem_req held high, mem_addr stable.
  - On mem_ready=1: write line, tag, valid=1 into the victim way; register the requested word.
  - In the same edge: cpu_valid=1, cpu_hit=0, mem_req=0, update LRU, → IDLE.
- Latency:
  - Hit response is 2 cycles after the acceptance edge.
  - Miss response arrives on the edge that samples mem_ready=1.
  - Next acceptance is possible in the cycle after cpu_valid.
- Victim selection:
  - WAYS=1: the single way.
  - WAYS=2: invalid way0 first, then invalid way1, else the LRU way.
  - LRU bit per set points to the least-recently-used way; each hit or fill marks the accessed way MRU.
- Boundary behaviour:
  - cpu_req while cpu_ready=0 is ignored, not queued.
  - mem_ready outside FILL is ignored.
  - Counters saturate at all-ones and do not wrap.
  - Reset during FILL drops mem_req immediately; the partially-handled request is discarded with no response.
  - Address at the top of space (all ones) works without wrap artefacts.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, LOOKUP, FILL).
  - clog2 helper function.
  - derived-width localparams OFF_W, IDX_W, TAG_W.
- One sub-module, cache_way:
  - valid/tag/data arrays for one way.
  - read port (tag-compare hit flag plus selected word).
  - write port (line fill).
  - asynchronous, active-low valid clear.
  - Instantiated WAYS times; the LRU array stays in the top module.

Test Plan:
- Reset, then read 1024 → mem_req=1 with mem_addr=1024; memory returns words 0xA0..0xA3 → cpu_valid with cpu_hit=0, cpu_rdata=0xA0; access_cnt=1, hit_cnt=0.
- Then reads 1025, 1026, 1027 → each a hit, 2 cycles after acceptance, data 0xA1..0xA3, no mem_req; end with access_cnt=4, hit_cnt=3.
- Read sequence 1024, 5120, 1024 (same index, different tag):
  - WAYS=1 → three misses.
  - WAYS=2 → miss, miss, hit.
- WAYS=2, same set, reads A=1024, B=5120, A, C=9216 → C evicts B; a following read of A hits, B misses.
- mem_ready delayed 7 cycles with cpu_req pulsed during the wait → request ignored, mem_req/mem_addr stable, exactly one cpu_valid.
- rst=0 asserted mid-FILL → mem_req=0 without a clock edge, counters 0, no cpu_valid; re-read of 1024 after release misses.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Shared types, default geometry and width helpers for the
//             parametrised read-only cache controller.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Default geometry of the controller.
    localparam int DEF_ADDR_W          = 15;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_WORDS_PER_BLOCK = 4;
    localparam int DEF_NUM_SETS        = 1024;
    localparam int DEF_WAYS            = 1;
    localparam int DEF_CNT_W           = 32;

    // Address split at the default geometry (offset / index / tag).
    localparam int OFF_W = clog2(DEF_WORDS_PER_BLOCK);
    localparam int IDX_W = clog2(DEF_NUM_SETS);
    localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_way.sv
`default_nettype none
// ============================================================================
//  Module   : cache_way
//  Purpose  : One way of the cache: valid bits, tag and data storage, a
//             combinational tag-compare read port and a whole-line fill port.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_way
    import cache_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int NUM_SETS        = DEF_NUM_SETS,
    localparam int c_off_w        = clog2(WORDS_PER_BLOCK),
    localparam int c_idx_w        = clog2(NUM_SETS),
    localparam int c_tag_w        = ADDR_W - c_idx_w - c_off_w
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [c_idx_w-1:0]                idx,
    input  logic [c_tag_w-1:0]                tag,
    input  logic [c_off_w-1:0]                off,
    output logic                              rd_valid,
    output logic                              rd_hit,
    output logic [DATA_W-1:0]                 rd_word,
    input  logic                              wr_en,
    input  logic [WORDS_PER_BLOCK*DATA_W-1:0] wr_line
);

    logic [NUM_SETS-1:0] r_valid;
    logic [c_tag_w-1:0]  r_tag_mem  [NUM_SETS];
    logic [DATA_W-1:0]   r_data_mem [NUM_SETS][WORDS_PER_BLOCK];

    // Valid bits: cleared by reset, set when a line is filled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[idx] <= 1'b1;
        end
    end

    // Tag and data storage: no reset, written on line fill only.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag_mem[idx] <= tag;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                r_data_mem[idx][i] <= wr_line[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_valid = r_valid[idx];
    assign rd_hit   = r_valid[idx] && (r_tag_mem[idx] == tag);
    assign rd_word  = r_data_mem[idx][off];

endmodule
`default_nettype wire

// File: rtl/param_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : param_cache_ctrl
//  Purpose  : Parametrised read-only blocking cache controller, 1- or 2-way
//             set associative with per-set LRU, req/ready line-fill handshake
//             and saturating hit/access statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module param_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int NUM_SETS        = DEF_NUM_SETS,
    parameter int WAYS            = DEF_WAYS,
    parameter int CNT_W           = DEF_CNT_W
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cpu_req,
    input  logic [ADDR_W-1:0]                 cpu_addr,
    output logic                              cpu_ready,
    output logic                              cpu_valid,
    output logic [DATA_W-1:0]                 cpu_rdata,
    output logic                              cpu_hit,
    output logic                              mem_req,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic                              mem_ready,
    input  logic [WORDS_PER_BLOCK*DATA_W-1:0] mem_data,
    output logic [CNT_W-1:0]                  hit_cnt,
    output logic [CNT_W-1:0]                  access_cnt
);

    localparam int c_off_w = clog2(WORDS_PER_BLOCK);
    localparam int c_idx_w = clog2(NUM_SETS);
    localparam int c_tag_w = ADDR_W - c_idx_w - c_off_w;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_hit_done;
    logic                w_miss;
    logic                w_fill_done;

    logic [ADDR_W-1:0]   r_addr;
    logic [c_tag_w-1:0]  w_tag;
    logic [c_idx_w-1:0]  w_idx;
    logic [c_off_w-1:0]  w_off;

    logic [WAYS-1:0]     w_way_valid;
    logic [WAYS-1:0]     w_way_hit;
    logic [WAYS-1:0]     w_way_we;
    logic [DATA_W-1:0]   w_way_word [WAYS];

    logic                w_hit_any;
    logic                w_hit_way;
    logic [DATA_W-1:0]   w_hit_word;
    logic [DATA_W-1:0]   w_fill_word;
    logic                w_victim;
    logic                w_lru_bit;

    logic [NUM_SETS-1:0] r_lru;
    logic                r_cpu_valid;
    logic                r_cpu_hit;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_access_cnt;

    assign w_tag = r_addr[ADDR_W-1 -: c_tag_w];
    assign w_idx = r_addr[c_off_w +: c_idx_w];
    assign w_off = r_addr[c_off_w-1:0];

    // Storage ways; all share the latched index/tag and the fill line.
    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way #(
            .ADDR_W          (ADDR_W),
            .DATA_W          (DATA_W),
            .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
            .NUM_SETS        (NUM_SETS)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .idx      (w_idx),
            .tag      (w_tag),
            .off      (w_off),
            .rd_valid (w_way_valid[g]),
            .rd_hit   (w_way_hit[g]),
            .rd_word  (w_way_word[g]),
            .wr_en    (w_way_we[g]),
            .wr_line  (mem_data)
        );
        assign w_way_we[g] = w_fill_done && (w_victim == 1'(g));
    end

    // Hit detection across ways and selection of the hitting word.
    always_comb begin
        w_hit_any  = 1'b0;
        w_hit_way  = 1'b0;
        w_hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_way_hit[w]) begin
                w_hit_any  = 1'b1;
                w_hit_way  = 1'(w);
                w_hit_word = w_way_word[w];
            end
        end
    end

    // Requested word picked out of the incoming line.
    always_comb begin
        w_fill_word = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            if (w_off == c_off_w'(i)) begin
                w_fill_word = mem_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // LRU is only meaningful with two ways; a direct-mapped cache has one victim.
    assign w_lru_bit = (WAYS == 2) ? r_lru[w_idx] : 1'b0;

    // Victim: lowest-numbered invalid way, otherwise the LRU way.
    always_comb begin
        w_victim = w_lru_bit;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_way_valid[w]) begin
                w_victim = 1'(w);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state action strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_hit_done  = 1'b0;
        w_miss      = 1'b0;
        w_fill_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (w_hit_any) begin
                    w_hit_done  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_miss      = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (mem_ready) begin
                    w_fill_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch, response registers and the memory request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_cpu_valid <= 1'b0;
            r_cpu_hit   <= 1'b0;
            r_cpu_rdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_cpu_valid <= 1'b0;
            r_cpu_hit   <= 1'b0;
            if (w_accept) begin
                r_addr <= cpu_addr;
            end
            if (w_hit_done) begin
                r_cpu_rdata <= w_hit_word;
                r_cpu_valid <= 1'b1;
                r_cpu_hit   <= 1'b1;
            end
            if (w_miss) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= {w_tag, w_idx, {c_off_w{1'b0}}};
            end
            if (w_fill_done) begin
                r_cpu_rdata <= w_fill_word;
                r_cpu_valid <= 1'b1;
                r_mem_req   <= 1'b0;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt    <= '0;
            r_access_cnt <= '0;
        end else begin
            if (w_accept && (r_access_cnt != '1)) begin
                r_access_cnt <= r_access_cnt + 1'b1;
            end
            if (w_hit_done && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
        end
    end

    // Per-set LRU pointer: the way not just touched becomes least recent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lru <= '0;
        end else if (w_hit_done) begin
            r_lru[w_idx] <= ~w_hit_way;
        end else if (w_fill_done) begin
            r_lru[w_idx] <= ~w_victim;
        end
    end

    assign cpu_ready  = (r_state == IDLE);
    assign cpu_valid  = r_cpu_valid;
    assign cpu_hit    = r_cpu_hit;
    assign cpu_rdata  = r_cpu_rdata;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign hit_cnt    = r_hit_cnt;
    assign access_cnt = r_access_cnt;

endmodule
`default_nettype wire

// File: tb/tb_param_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_cache_ctrl
//  Purpose  : Self-checking bench for param_cache_ctrl. Instance 0 is
//             direct-mapped with 2-bit counters, instance 1 is 2-way with
//             32-bit counters. Expected responses are queued at request time
//             and compared when cpu_valid pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         cpu_req   [2];
    logic [14:0]  cpu_addr  [2];
    logic         cpu_ready [2];
    logic         cpu_valid [2];
    logic [31:0]  cpu_rdata [2];
    logic         cpu_hit   [2];
    logic         mem_req   [2];
    logic [14:0]  mem_addr  [2];
    logic         mem_ready [2];
    logic [127:0] mem_data  [2];
    logic [1:0]   hit_cnt0, acc_cnt0;
    logic [31:0]  hit_cnt1, acc_cnt1;

    int           n_vec = 0;
    int           n_err = 0;
    int           vcnt      [2];
    int           mem_delay [2];
    int           mcnt      [2];
    logic [14:0]  exp_maddr [2];
    logic [32:0]  q0 [$];
    logic [32:0]  q1 [$];

    always #5 clk = ~clk;

    param_cache_ctrl #(.WAYS(1), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[0]), .cpu_addr(cpu_addr[0]), .cpu_ready(cpu_ready[0]),
        .cpu_valid(cpu_valid[0]), .cpu_rdata(cpu_rdata[0]), .cpu_hit(cpu_hit[0]),
        .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_ready(mem_ready[0]),
        .mem_data(mem_data[0]), .hit_cnt(hit_cnt0), .access_cnt(acc_cnt0)
    );

    param_cache_ctrl #(.WAYS(2), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[1]), .cpu_addr(cpu_addr[1]), .cpu_ready(cpu_ready[1]),
        .cpu_valid(cpu_valid[1]), .cpu_rdata(cpu_rdata[1]), .cpu_hit(cpu_hit[1]),
        .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_ready(mem_ready[1]),
        .mem_data(mem_data[1]), .hit_cnt(hit_cnt1), .access_cnt(acc_cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents: word at address 1024 is 0xA0, rising by one per word.
    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return 32'(a) + 32'h0000_00A0 - 32'd1024;
    endfunction

    function automatic logic [127:0] mem_line(input logic [14:0] ba);
        logic [127:0] l;
        logic [14:0]  a;
        for (int i = 0; i < 4; i++) begin
            a = ba + 15'(i);
            l[i*32 +: 32] = mem_word(a);
        end
        return l;
    endfunction

    task automatic push_exp(input int k, input logic [32:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    // Memory model: answers a held mem_req after mem_delay[k] cycles.
    initial begin
        for (int k = 0; k < 2; k++) begin
            mem_ready[k] = 1'b0;
            mem_data[k]  = '0;
            mcnt[k]      = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst || !mem_req[k]) begin
                    mcnt[k]      = 0;
                    mem_ready[k] = 1'b0;
                end else begin
                    if (mcnt[k] == 0) chk("mem_addr", mem_addr[k], exp_maddr[k]);
                    mcnt[k]++;
                    if (mcnt[k] > mem_delay[k]) begin
                        mem_ready[k] = 1'b1;
                        mem_data[k]  = mem_line(mem_addr[k]);
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every cpu_valid pulse.
    initial begin
        logic [32:0] e;
        vcnt[0] = 0;
        vcnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (cpu_valid[k]) begin
                    vcnt[k]++;
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        chk("spurious_valid", 1'b1, 1'b0);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("rdata", cpu_rdata[k], e[31:0]);
                        chk("hit", cpu_hit[k], e[32]);
                    end
                end
            end
        end
    end

    task automatic do_read(input int k, input logic [14:0] a, input logic exp_hit);
        int   n;
        logic got;
        logic seen;
        @(negedge clk);
        n = 0;
        while (!cpu_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_ready[k]) chk("ready_timeout", 1'b0, 1'b1);
        exp_maddr[k] = a & 15'h7FFC;
        push_exp(k, {exp_hit, mem_word(a)});
        cpu_req[k]  = 1'b1;
        cpu_addr[k] = a;
        @(posedge clk);
        #1;
        cpu_req[k] = 1'b0;
        n    = 0;
        got  = 1'b0;
        seen = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            seen = seen | mem_req[k];
            got  = cpu_valid[k];
        end
        chk("resp_seen", got, 1'b1);
        if (exp_hit) chk("hit_latency", n, 2);
        chk("mem_req_used", seen, !exp_hit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Miss with a slow memory and a stray request while the fill is pending.
    task automatic stall_test();
        int          n;
        int          vb;
        logic [31:0] ab;
        logic [14:0] ma;
        logic        stable;
        mem_delay[1] = 7;
        @(negedge clk);
        vb = vcnt[1];
        ab = acc_cnt1;
        exp_maddr[1] = 15'd2048;
        push_exp(1, {1'b0, mem_word(15'd2048)});
        cpu_req[1]  = 1'b1;
        cpu_addr[1] = 15'd2048;
        @(posedge clk);
        #1;
        cpu_req[1] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req[1] && n < 20);
        ma     = mem_addr[1];
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cpu_req[1]  = 1'b1;
                cpu_addr[1] = 15'd5000;
            end else begin
                cpu_req[1]  = 1'b0;
            end
            stable = stable & mem_req[1] & (mem_addr[1] == ma) & !cpu_valid[1];
        end
        chk("stall_stable", stable, 1'b1);
        n = 0;
        while (!cpu_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("stall_one_valid", vcnt[1] - vb, 1);
        chk("stall_access_once", acc_cnt1 - ab, 1);
        mem_delay[1] = 0;
    endtask

    // Reset asserted between clock edges while both instances are filling.
    task automatic reset_mid_fill();
        int vb0;
        int vb1;
        mem_delay[0] = 20;
        mem_delay[1] = 20;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            exp_maddr[k] = 15'd6144;
            cpu_req[k]   = 1'b1;
            cpu_addr[k]  = 15'd6144;
        end
        @(posedge clk);
        #1;
        cpu_req[0] = 1'b0;
        cpu_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("fill_req0", mem_req[0], 1'b1);
        chk("fill_req1", mem_req[1], 1'b1);
        vb0 = vcnt[0];
        vb1 = vcnt[1];
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mem_req0", mem_req[0], 1'b0);
        chk("rst_mem_req1", mem_req[1], 1'b0);
        chk("rst_acc0", acc_cnt0, 0);
        chk("rst_acc1", acc_cnt1, 0);
        chk("rst_hit1", hit_cnt1, 0);
        chk("rst_ready1", cpu_ready[1], 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_delay[0] = 0;
        mem_delay[1] = 0;
        repeat (3) @(negedge clk);
        chk("rst_no_valid0", vcnt[0] - vb0, 0);
        chk("rst_no_valid1", vcnt[1] - vb1, 0);
        do_read(0, 15'd1024, 1'b0);
        do_read(1, 15'd1024, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            cpu_req[k]   = 1'b0;
            cpu_addr[k]  = '0;
            mem_delay[k] = 0;
            exp_maddr[k] = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        for (int k = 0; k < 2; k++) begin
            chk("rst_cpu_ready", cpu_ready[k], 1'b1);
            chk("rst_cpu_valid", cpu_valid[k], 1'b0);
            chk("rst_cpu_hit", cpu_hit[k], 1'b0);
            chk("rst_cpu_rdata", cpu_rdata[k], 0);
            chk("rst_mem_req", mem_req[k], 1'b0);
            chk("rst_mem_addr", mem_addr[k], 0);
        end
        chk("rst_cnt0", {hit_cnt0, acc_cnt0}, 0);
        chk("rst_cnt1", {hit_cnt1, acc_cnt1}, 0);
        rst = 1'b1;

        // One miss followed by hits on the rest of the line.
        for (int k = 0; k < 2; k++) begin
            do_read(k, 15'd1024, 1'b0);
            do_read(k, 15'd1025, 1'b1);
            do_read(k, 15'd1026, 1'b1);
            do_read(k, 15'd1027, 1'b1);
        end
        @(negedge clk);
        chk("acc_cnt1", acc_cnt1, 4);
        chk("hit_cnt1", hit_cnt1, 3);
        chk("acc_cnt0_sat", acc_cnt0, 3);
        chk("hit_cnt0", hit_cnt0, 3);
        do_read(0, 15'd1024, 1'b1);
        @(negedge clk);
        chk("acc_cnt0_hold", acc_cnt0, 3);
        chk("hit_cnt0_sat", hit_cnt0, 3);

        // Conflicting tags in one set.
        do_reset();
        do_read(0, 15'd1024, 1'b0);
        do_read(0, 15'd5120, 1'b0);
        do_read(0, 15'd1024, 1'b0);
        do_read(1, 15'd1024, 1'b0);
        do_read(1, 15'd5120, 1'b0);
        do_read(1, 15'd1024, 1'b1);

        // LRU replacement in the 2-way instance.
        do_reset();
        do_read(1, 15'd1024, 1'b0);
        do_read(1, 15'd5120, 1'b0);
        do_read(1, 15'd1024, 1'b1);
        do_read(1, 15'd9216, 1'b0);
        do_read(1, 15'd1024, 1'b1);
        do_read(1, 15'd5120, 1'b0);
        do_read(1, 15'd9216, 1'b0);

        stall_test();

        // Top of the address space.
        do_read(1, 15'h7FFF, 1'b0);
        do_read(1, 15'h7FFC, 1'b1);
        do_read(1, 15'h7FFF, 1'b1);

        reset_mid_fill();

        repeat (3) @(negedge clk);
        chk("queue0_empty", q0.size(), 0);
        chk("queue1_empty", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
